// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle RV32I control unit: sequences IF/ID/EX/MEM/WB, drives datapath strobes,
// handles variable-latency memory via mem_ready and counts retired instructions.
module multicycle_ctrl_fsm #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [6:0]       opcode,
   input  logic             bcond,
   input  logic             is_halted,
   input  logic             mem_ready,
   output logic             write_enable_pc,
   output logic [1:0]       pc_source,
   output logic             is_ecall,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic             i_or_d,
   output logic             reg_write,
   output logic [1:0]       wb_sel,
   output logic             alu_src_a,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] instret
);

   localparam logic [2:0] S_IF   = 3'd0;
   localparam logic [2:0] S_ID   = 3'd1;
   localparam logic [2:0] S_EX   = 3'd2;
   localparam logic [2:0] S_MEM  = 3'd3;
   localparam logic [2:0] S_WB   = 3'd4;
   localparam logic [2:0] S_HALT = 3'd5;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;

   logic [2:0]       state_reg;
   logic [2:0]       state_next;
   logic [CNT_W-1:0] instret_reg;
   logic             retire;
   logic             known_op;

   assign known_op = (opcode == OP_R)      || (opcode == OP_I)     ||
                     (opcode == OP_LOAD)   || (opcode == OP_STORE) ||
                     (opcode == OP_BRANCH) || (opcode == OP_JAL)   ||
                     (opcode == OP_JALR)   || (opcode == OP_ECALL);

   // State register and retired-instruction counter
   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg   <= S_IF;
         instret_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (retire)
            instret_reg <= instret_reg + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   // Next-state logic; retire marks every transition that completes an instruction
   always_comb begin
      state_next = S_IF;
      retire     = 1'b0;
      case (state_reg)
         S_IF: state_next = mem_ready ? S_ID : S_IF;
         S_ID: begin
            if (opcode == OP_ECALL) begin
               retire     = 1'b1;
               state_next = is_halted ? S_HALT : S_IF;
            end else if (!known_op) begin
               retire     = 1'b1;
               state_next = S_IF;
            end else begin
               state_next = S_EX;
            end
         end
         S_EX: begin
            case (opcode)
               OP_R, OP_I:          state_next = S_WB;
               OP_LOAD, OP_STORE:   state_next = S_MEM;
               OP_BRANCH, OP_JAL,
               OP_JALR: begin
                  state_next = S_IF;
                  retire     = 1'b1;
               end
               default:             state_next = S_IF;
            endcase
         end
         S_MEM: begin
            if (opcode == OP_LOAD) begin
               state_next = mem_ready ? S_WB : S_MEM;
            end else if (opcode == OP_STORE) begin
               state_next = mem_ready ? S_IF : S_MEM;
               retire     = mem_ready;
            end else begin
               state_next = S_IF;
            end
         end
         S_WB: begin
            state_next = S_IF;
            retire     = 1'b1;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_IF;
      endcase
   end

   // Output decode; state-changing strobes are suppressed while reset is held
   always_comb begin
      write_enable_pc = 1'b0;
      pc_source       = 2'b00;
      is_ecall        = 1'b0;
      ir_write        = 1'b0;
      mem_read        = 1'b0;
      mem_write       = 1'b0;
      i_or_d          = 1'b0;
      reg_write       = 1'b0;
      wb_sel          = 2'b00;
      alu_src_a       = 1'b0;
      alu_src_b       = 2'b00;
      alu_op          = 2'b00;
      case (state_reg)
         S_IF: begin
            mem_read = 1'b1;
            ir_write = mem_ready;
         end
         S_ID: begin
            alu_src_b = 2'b10;
            if (opcode == OP_ECALL) begin
               is_ecall        = 1'b1;
               write_enable_pc = !is_halted;
            end else if (!known_op) begin
               write_enable_pc = 1'b1;
            end
         end
         S_EX: begin
            case (opcode)
               OP_R: begin
                  alu_src_a = 1'b1;
                  alu_op    = 2'b10;
               end
               OP_I: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
                  alu_op    = 2'b10;
               end
               OP_LOAD, OP_STORE: begin
                  alu_src_a = 1'b1;
                  alu_src_b = 2'b10;
               end
               OP_BRANCH: begin
                  alu_src_a       = 1'b1;
                  alu_op          = 2'b01;
                  write_enable_pc = 1'b1;
                  pc_source       = bcond ? 2'b01 : 2'b00;
               end
               OP_JAL: begin
                  reg_write       = 1'b1;
                  wb_sel          = 2'b10;
                  write_enable_pc = 1'b1;
                  pc_source       = 2'b01;
               end
               OP_JALR: begin
                  alu_src_a       = 1'b1;
                  alu_src_b       = 2'b10;
                  reg_write       = 1'b1;
                  wb_sel          = 2'b10;
                  write_enable_pc = 1'b1;
                  pc_source       = 2'b10;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            i_or_d = 1'b1;
            if (opcode == OP_LOAD) begin
               mem_read = 1'b1;
            end else if (opcode == OP_STORE) begin
               mem_write       = 1'b1;
               write_enable_pc = mem_ready;
            end
         end
         S_WB: begin
            reg_write       = 1'b1;
            wb_sel          = (opcode == OP_LOAD) ? 2'b01 : 2'b00;
            write_enable_pc = 1'b1;
         end
         default: ;
      endcase
      if (reset) begin
         write_enable_pc = 1'b0;
         reg_write       = 1'b0;
         mem_write       = 1'b0;
         ir_write        = 1'b0;
      end
   end

   assign state   = state_reg;
   assign instret = instret_reg;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm: steps instructions through the FSM and
// checks strobes, state and instret with immediate assertions.
module tb_multicycle_ctrl_fsm;

   logic        clk = 1'b0;
   logic        reset;
   logic [6:0]  opcode;
   logic        bcond;
   logic        is_halted;
   logic        mem_ready;
   logic        write_enable_pc;
   logic [1:0]  pc_source;
   logic        is_ecall;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic        i_or_d;
   logic        reg_write;
   logic [1:0]  wb_sel;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [1:0]  alu_op;
   logic [2:0]  state;
   logic [31:0] instret;

   int tests_run = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   multicycle_ctrl_fsm #(.CNT_W(32)) dut (
      .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond),
      .is_halted(is_halted), .mem_ready(mem_ready),
      .write_enable_pc(write_enable_pc), .pc_source(pc_source),
      .is_ecall(is_ecall), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .i_or_d(i_or_d), .reg_write(reg_write),
      .wb_sel(wb_sel), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .state(state), .instret(instret)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
      $display("[TB] t=%0t %s observed=%0h expected=%0h", $time, tag, obs, exp);
   endtask

   // Advance one clock; inputs are then changed at the negedge and sampled 1 time unit later
   task automatic tick();
      @(negedge clk);
   endtask

   initial begin
      reset = 1'b1; opcode = 7'b0; bcond = 1'b0; is_halted = 1'b0; mem_ready = 1'b1;
      tick(); tick(); #1;
      chk("rst_state", state, 0);
      chk("rst_instret", instret, 0);
      chk("rst_ir_write_forced", ir_write, 0);
      chk("rst_mem_read", mem_read, 1);

      // ADD
      reset = 1'b0; opcode = 7'b0110011; #1;
      chk("add_if_ir_write", ir_write, 1);
      tick(); #1;
      chk("add_id_state", state, 1);
      chk("add_id_alu_src_b", alu_src_b, 2);
      chk("add_id_wepc", write_enable_pc, 0);
      tick(); #1;
      chk("add_ex_state", state, 2);
      chk("add_ex_alu_op", alu_op, 2);
      chk("add_ex_alu_src_a", alu_src_a, 1);
      chk("add_ex_wepc", write_enable_pc, 0);
      tick(); #1;
      chk("add_wb_state", state, 4);
      chk("add_wb_wepc", write_enable_pc, 1);
      chk("add_wb_reg_write", reg_write, 1);
      chk("add_wb_sel", wb_sel, 0);
      tick(); #1;
      chk("add_done_state", state, 0);
      chk("add_instret", instret, 1);

      // LW with three wait cycles in MEM
      opcode = 7'b0000011;
      tick(); tick(); #1;
      chk("lw_ex_state", state, 2);
      chk("lw_ex_alu_op", alu_op, 0);
      tick(); mem_ready = 1'b0; #1;
      for (int i = 0; i < 3; i++) begin
         chk("lw_mem_wait_state", state, 3);
         chk("lw_mem_wait_rd", {31'b0, mem_read & i_or_d}, 1);
         tick(); #1;
      end
      mem_ready = 1'b1; #1;
      chk("lw_mem_ready_state", state, 3);
      chk("lw_mem_ready_rd", {31'b0, mem_read & i_or_d}, 1);
      chk("lw_mem_ir_write", ir_write, 0);
      tick(); #1;
      chk("lw_wb_state", state, 4);
      chk("lw_wb_sel", wb_sel, 1);
      tick(); #1;
      chk("lw_done_state", state, 0);
      chk("lw_instret", instret, 2);

      // BEQ not taken, then taken
      opcode = 7'b1100011; bcond = 1'b0;
      tick(); tick(); #1;
      chk("beq0_ex_state", state, 2);
      chk("beq0_pc_source", pc_source, 0);
      chk("beq0_wepc", write_enable_pc, 1);
      chk("beq0_alu_op", alu_op, 1);
      tick(); #1;
      chk("beq0_done_state", state, 0);
      chk("beq0_instret", instret, 3);
      tick(); tick(); bcond = 1'b1; #1;
      chk("beq1_pc_source", pc_source, 1);
      chk("beq1_wepc", write_enable_pc, 1);
      tick(); #1;
      chk("beq1_done_state", state, 0);
      chk("beq1_instret", instret, 4);

      // JALR
      opcode = 7'b1100111; bcond = 1'b0;
      tick(); tick(); #1;
      chk("jalr_pc_source", pc_source, 2);
      chk("jalr_reg_write", reg_write, 1);
      chk("jalr_wb_sel", wb_sel, 2);
      tick(); #1;
      chk("jalr_done_state", state, 0);
      chk("jalr_instret", instret, 5);

      // ecall, non-halting then halting
      opcode = 7'b1110011; is_halted = 1'b0;
      tick(); #1;
      chk("ecall0_is_ecall", is_ecall, 1);
      chk("ecall0_wepc", write_enable_pc, 1);
      tick(); #1;
      chk("ecall0_state", state, 0);
      chk("ecall0_instret", instret, 6);
      is_halted = 1'b1;
      tick(); #1;
      chk("ecall1_is_ecall", is_ecall, 1);
      chk("ecall1_wepc", write_enable_pc, 0);
      tick(); #1;
      chk("ecall1_state", state, 5);
      for (int i = 0; i < 20; i++) begin
         tick(); #1;
         chk("halt_state", state, 5);
         chk("halt_mem_read", mem_read, 0);
      end
      chk("halt_instret", instret, 7);
      reset = 1'b1;
      tick(); #1;
      reset = 1'b0; is_halted = 1'b0; #1;
      chk("halt_exit_state", state, 0);
      chk("halt_exit_instret", instret, 0);

      // Unknown opcode retires as NOP from ID
      opcode = 7'b0000000;
      tick(); #1;
      chk("nop_id_wepc", write_enable_pc, 1);
      tick(); #1;
      chk("nop_state", state, 0);
      chk("nop_instret", instret, 1);

      // SW aborted by reset on the second MEM wait cycle
      opcode = 7'b0100011;
      tick(); tick(); tick(); mem_ready = 1'b0; #1;
      chk("sw_mem_state", state, 3);
      chk("sw_mem_write", mem_write, 1);
      chk("sw_mem_wepc_wait", write_enable_pc, 0);
      tick(); reset = 1'b1; #1;
      chk("sw_rst_mem_write", mem_write, 0);
      tick(); reset = 1'b0; mem_ready = 1'b1; #1;
      chk("sw_rst_state", state, 0);
      chk("sw_rst_instret", instret, 0);

      // SW completing normally
      tick(); tick(); tick(); #1;
      chk("sw_full_mem_write", mem_write, 1);
      chk("sw_full_wepc", write_enable_pc, 1);
      tick(); #1;
      chk("sw_full_state", state, 0);
      chk("sw_full_instret", instret, 1);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
